zigbee_pad_mux: RTL

- Pin-multiplexing stage inside zigbee_platform, directly behind the pad ring.
- Consumes the raw pad buses: mux_i[21:0] and sel_i[1:0], both asynchronous to clk_i.
- Produces the pad output bus mux_o[17:0].
- Presents byte-wide TX/RX FIFO handshakes and a debug tap to the Zigbee core, with a glitch-free mode switch.

---
 rtl/zigbee_pad_mux.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/zigbee_pad_mux.sv
// Pad-ring pin multiplexer: synchronised pad strobes feed byte TX/RX FIFOs, with a guarded mode switch.
// Optional: define ZIGBEE_PAD_MUX_PARITY_EN to drive mux_o[17] with even parity of mux_o[16:0] in RUN.
module zigbee_pad_mux #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned GUARD_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [1:0]  sel_i,
  input  logic [21:0] mux_i,
  output logic [17:0] mux_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic [17:0] dbg_i
);
  localparam int unsigned PW         = (FIFO_DEPTH == 4) ? 2 : 1;
  localparam logic [2:0]  FULL_LVL   = 3'(FIFO_DEPTH);
  localparam logic [7:0]  GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  typedef enum logic {RUN, GUARD} state_t;

  logic [1:0]  sel_m, sel_s;
  logic [17:0] in_m, in_s;
  logic [2:0]  edge_d, rise;
  logic        unused_rsvd;

  assign unused_rsvd = ^mux_i[21:18];

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sel_m  <= '0;
      sel_s  <= '0;
      in_m   <= '0;
      in_s   <= '0;
      edge_d <= '0;
    end else begin
      sel_m  <= sel_i;
      sel_s  <= sel_m;
      in_m   <= mux_i[17:0];
      in_s   <= in_m;
      edge_d <= in_s[10:8];
    end
  end

  // rise[0]=TX push strobe, rise[1]=RX pop strobe, rise[2]=overflow clear
  assign rise = in_s[10:8] & ~edge_d;

  state_t      state;
  logic [1:0]  active, guard_sel;
  logic [7:0]  cnt;
  logic        run;
  logic [17:0] mux_next;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [2:0]    tx_lvl, rx_lvl;
  logic          tx_ne, tx_full, rx_ne, rx_full, ovf;
  logic          tx_req, tx_push, tx_pop, ovf_set, ovf_clr, rx_push, rx_pop;
  logic [7:0]    rx_head;

  assign run     = (state == RUN);
  assign tx_ne   = (tx_lvl != '0);
  assign tx_full = (tx_lvl == FULL_LVL);
  assign rx_ne   = (rx_lvl != '0);
  assign rx_full = (rx_lvl == FULL_LVL);
  assign rx_head = rx_ne ? rx_mem[rx_rd] : '0;

  assign tx_valid_o = tx_ne;
  assign tx_data_o  = tx_ne ? tx_mem[tx_rd] : '0;
  assign rx_ready_o = ~rx_full;

  // A push into a full TX FIFO is still accepted when the core pops the head in the same cycle.
  assign tx_pop  = tx_ne & tx_ready_i;
  assign tx_req  = rise[0] & run & (active == 2'd0);
  assign tx_push = tx_req & (~tx_full | tx_pop);
  assign ovf_set = tx_req & tx_full & ~tx_pop;
  assign ovf_clr = rise[2] & run;
  assign rx_push = rx_valid_i & ~rx_full;
  assign rx_pop  = rise[1] & run & (active == 2'd1) & rx_ne;

  always_comb begin
    mux_next = '0;
    if (run) begin
      case (active)
        2'd0:    mux_next = {12'd0, rx_ne, ovf, tx_full, tx_lvl};
        2'd1:    mux_next = {5'd0, rx_full, rx_lvl, rx_ne, rx_head};
        2'd2:    mux_next = dbg_i;
        default: mux_next = in_s;
      endcase
`ifdef ZIGBEE_PAD_MUX_PARITY_EN
      mux_next[17] = ^mux_next[16:0];
`endif
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state     <= RUN;
      active    <= '0;
      guard_sel <= '0;
      cnt       <= '0;
      mux_o     <= '0;
    end else begin
      mux_o <= mux_next;
      case (state)
        RUN: begin
          if (sel_s != active) begin
            state     <= GUARD;
            guard_sel <= sel_s;
            cnt       <= GUARD_LOAD;
          end
        end
        GUARD: begin
          if (sel_s != guard_sel) begin
            guard_sel <= sel_s;
            cnt       <= GUARD_LOAD;
          end else if (cnt == '0) begin
            active <= sel_s;
            state  <= RUN;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_lvl <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_lvl <= '0;
      ovf    <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
      tx_lvl <= tx_lvl + {2'b00, tx_push} - {2'b00, tx_pop};
      rx_lvl <= rx_lvl + {2'b00, rx_push} - {2'b00, rx_pop};
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr] <= in_s[7:0];
    if (rx_push) rx_mem[rx_wr] <= rx_data_i;
  end
endmodule
